// File: rtl/rc_servo_pkg.sv
// Shared constants and helpers for the RC servo pulse generator family.
package rc_servo_pkg;

   localparam int FRAME_US_DEF = 20000;
   localparam int PW_MIN_DEF   = 1000;
   localparam int PW_MAX_DEF   = 2000;
   localparam int PW_DEF_DEF   = 1500;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic logic [15:0] clamp_pw(input logic [15:0] pw,
                                            input logic [15:0] lo,
                                            input logic [15:0] hi);
      return (pw < lo) ? lo : ((pw > hi) ? hi : pw);
   endfunction

endpackage

// File: rtl/rc_timebase.sv
// Shared microsecond timebase: clock prescaler plus in-frame microsecond counter.
module rc_timebase
   import rc_servo_pkg::*;
#(
   parameter int DIV      = 50,
   parameter int FRAME_US = FRAME_US_DEF,
   parameter int US_W     = 15
) (
   input  logic            clk,
   input  logic            rst,
   output logic            us_tick,
   output logic            frame_load,
   output logic [US_W-1:0] usec_next
);

   localparam int PS_W = (DIV > 1) ? clog2(DIV) : 1;

   logic [PS_W-1:0] presc;
   logic [US_W-1:0] usec;

   assign us_tick    = (presc == PS_W'(DIV - 1));
   assign frame_load = us_tick && (usec == US_W'(FRAME_US - 1));
   // Only meaningful on us_tick: the microsecond that starts at this edge.
   assign usec_next  = frame_load ? '0 : usec + US_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         usec  <= '0;
      end else if (us_tick) begin
         presc <= '0;
         usec  <= usec_next;
      end else begin
         presc <= presc + PS_W'(1);
      end
   end

endmodule

// File: rtl/rc_servo_bank.sv
// Multi-channel RC servo pulse generator with frame-synchronous width updates
// and a per-channel silence watchdog that reverts to the failsafe width.
module rc_servo_bank
   import rc_servo_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int SYS_CLK        = 50000000,
   parameter int FRAME_US       = FRAME_US_DEF,
   parameter int PW_MIN         = PW_MIN_DEF,
   parameter int PW_MAX         = PW_MAX_DEF,
   parameter int PW_DEF         = PW_DEF_DEF,
   parameter int TIMEOUT_FRAMES = 50,
   localparam int CH_W          = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [15:0]       wr_pw,
   input  logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] out,
   output logic              frame_start,
   output logic [NUM_CH-1:0] failsafe
);

   localparam int DIV  = SYS_CLK / 1000000;
   localparam int US_W = (FRAME_US > 1) ? clog2(FRAME_US) : 1;
   localparam int WD_W = (TIMEOUT_FRAMES > 0) ? clog2(TIMEOUT_FRAMES + 1) : 1;

   logic            us_tick;
   logic            frame_load;
   logic [US_W-1:0] usec_next;
   logic            wr_ok;
   logic [15:0]     wr_pw_c;

   rc_timebase #(
      .DIV      (DIV),
      .FRAME_US (FRAME_US),
      .US_W     (US_W)
   ) u_timebase (
      .clk        (clk),
      .rst        (rst),
      .us_tick    (us_tick),
      .frame_load (frame_load),
      .usec_next  (usec_next)
   );

   // frame_start marks the clock whose edge loads the active widths, so a
   // write on this same clock lands in shadow only after the load sampled it.
   assign frame_start = frame_load;
   assign wr_ok       = wr_en && (int'(wr_ch) < NUM_CH);
   assign wr_pw_c     = clamp_pw(wr_pw, 16'(PW_MIN), 16'(PW_MAX));

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [15:0] shadow;
      logic [15:0] active;
      logic [15:0] active_next;
      logic        armed;
      logic        armed_next;
      logic        wr_hit;
      logic        wd_expire;
      logic        out_q;
      logic        fs_q;

      assign wr_hit      = wr_ok && (wr_ch == CH_W'(g));
      assign active_next = frame_load ? shadow : active;
      // Armed only at a frame load, so enabling mid-frame never yields a runt pulse.
      assign armed_next  = frame_load ? ch_en[g] : (armed && ch_en[g]);

      always_ff @(posedge clk) begin
         if (rst) begin
            shadow <= 16'(PW_DEF);
            active <= 16'(PW_DEF);
            armed  <= 1'b0;
            out_q  <= 1'b0;
         end else begin
            active <= active_next;
            armed  <= armed_next;
            if (us_tick)
               out_q <= armed_next && (16'(usec_next) < active_next);
            if (wr_hit)
               shadow <= wr_pw_c;
            else if (wd_expire)
               shadow <= 16'(PW_DEF);
         end
      end

      if (TIMEOUT_FRAMES > 0) begin : g_wd
         logic [WD_W-1:0] wdog;

         assign wd_expire = frame_load && !wr_hit && (wdog == WD_W'(TIMEOUT_FRAMES - 1));

         always_ff @(posedge clk) begin
            if (rst) begin
               wdog <= '0;
               fs_q <= 1'b0;
            end else if (wr_hit) begin
               wdog <= '0;
               fs_q <= 1'b0;
            end else if (frame_load && (wdog != WD_W'(TIMEOUT_FRAMES))) begin
               wdog <= wdog + WD_W'(1);
               if (wd_expire)
                  fs_q <= 1'b1;
            end
         end
      end else begin : g_nowd
         assign wd_expire = 1'b0;
         assign fs_q      = 1'b0;
      end

      assign out[g]      = out_q;
      assign failsafe[g] = fs_q;
   end

endmodule

// File: tb/tb_rc_servo_bank.sv
// Directed bench for rc_servo_bank with a frame-level behavioural model checked every cycle.
module tb_rc_servo_bank;

   localparam int NUM_CH   = 5;
   localparam int SYS_CLK  = 2000000;
   localparam int DIV      = SYS_CLK / 1000000;
   localparam int FRAME_US = 100;
   localparam int PW_MIN   = 20;
   localparam int PW_MAX   = 60;
   localparam int PW_DEF   = 40;
   localparam int TO       = 3;
   localparam int P        = DIV * FRAME_US;
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              clk;
   logic              rst;
   logic              wr_en;
   logic [CH_W-1:0]   wr_ch;
   logic [15:0]       wr_pw;
   logic [NUM_CH-1:0] ch_en;
   logic [NUM_CH-1:0] out;
   logic              frame_start;
   logic [NUM_CH-1:0] failsafe;

   int n_pass  = 0;
   int n_total = 0;
   int meas[NUM_CH];

   rc_servo_bank #(
      .NUM_CH         (NUM_CH),
      .SYS_CLK        (SYS_CLK),
      .FRAME_US       (FRAME_US),
      .PW_MIN         (PW_MIN),
      .PW_MAX         (PW_MAX),
      .PW_DEF         (PW_DEF),
      .TIMEOUT_FRAMES (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_ch       (wr_ch),
      .wr_pw       (wr_pw),
      .ch_en       (ch_en),
      .out         (out),
      .frame_start (frame_start),
      .failsafe    (failsafe)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int clampw(input int v);
      return (v < PW_MIN) ? PW_MIN : ((v > PW_MAX) ? PW_MAX : v);
   endfunction

   // Model: n counts clocks since reset; frames are P clocks, microseconds DIV clocks.
   int                m_n;
   bit                m_started = 0;
   int                m_shadow[NUM_CH];
   int                m_active[NUM_CH];
   int                m_age[NUM_CH];
   logic [NUM_CH-1:0] m_fs;
   logic [NUM_CH-1:0] m_ok;
   logic [NUM_CH-1:0] m_out;

   always @(posedge clk) begin
      bit is_load, is_tick, valid_wr;
      int u;
      m_started = 1;
      if (rst) begin
         m_n = 0;
         m_fs = '0;
         m_ok = '0;
         m_out = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_shadow[i] = PW_DEF;
            m_active[i] = PW_DEF;
            m_age[i] = 0;
         end
      end else begin
         is_load  = ((m_n + 1) % P) == 0;
         is_tick  = ((m_n + 1) % DIV) == 0;
         valid_wr = wr_en && (int'(wr_ch) < NUM_CH);
         m_n++;
         if (is_load) begin
            for (int i = 0; i < NUM_CH; i++) begin
               m_active[i] = m_shadow[i];
               m_ok[i] = ch_en[i];
               if (!(valid_wr && int'(wr_ch) == i) && m_age[i] < TO) begin
                  m_age[i]++;
                  if (m_age[i] == TO) begin
                     m_shadow[i] = PW_DEF;
                     m_fs[i] = 1'b1;
                  end
               end
            end
         end
         if (valid_wr) begin
            m_shadow[wr_ch] = clampw(int'(wr_pw));
            m_age[wr_ch] = 0;
            m_fs[wr_ch] = 1'b0;
         end
         for (int i = 0; i < NUM_CH; i++)
            if (!ch_en[i]) m_ok[i] = 1'b0;
         if (is_tick) begin
            u = (m_n / DIV) % FRAME_US;
            for (int i = 0; i < NUM_CH; i++)
               m_out[i] = m_ok[i] && (u < m_active[i]);
         end
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         check("model_out", int'(out), int'(m_out));
         check("model_failsafe", int'(failsafe), int'(m_fs));
         check("model_frame_start", int'(frame_start), int'((m_n % P) == P - 1));
      end
   end

   task automatic wait_fs(input int limit, output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!frame_start && k < limit);
      check("frame_start_seen", int'(frame_start), 1);
   endtask

   // Starts at a frame_start negedge, counts high clocks per channel over one
   // frame, and ends at the next frame_start negedge. wr_at<0 means no write.
   task automatic measure(input int wr_at, input int ch, input int pw);
      for (int i = 0; i < NUM_CH; i++) meas[i] = 0;
      for (int k = 0; k < P; k++) begin
         if (k == wr_at) begin
            wr_en = 1'b1;
            wr_ch = CH_W'(ch);
            wr_pw = 16'(pw);
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clk);
         for (int i = 0; i < NUM_CH; i++) meas[i] += int'(out[i]);
      end
      wr_en = 1'b0;
   endtask

   initial begin
      int k, hi;
      rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_pw = '0; ch_en = '1;
      repeat (3) @(negedge clk);
      check("reset_out", int'(out), 0);
      check("reset_failsafe", int'(failsafe), 0);
      check("reset_frame_start", int'(frame_start), 0);
      rst = 1'b0;

      // defaults and frame period
      wait_fs(2 * P, k);
      check("first_frame_start", k, P - 1);
      wait_fs(2 * P, k);
      check("frame_period", k, P);
      measure(-1, 0, 0);
      check("default_ch0", meas[0], PW_DEF * DIV);
      check("default_ch4", meas[4], PW_DEF * DIV);

      // mid-frame write takes effect next frame
      measure(50, 1, 30);
      check("midwrite_cur_ch1", meas[1], PW_DEF * DIV);
      measure(-1, 0, 0);
      check("midwrite_next_ch1", meas[1], 60);
      check("midwrite_next_ch0", meas[0], 80);

      // clamping
      measure(50, 0, 5);
      measure(-1, 0, 0);
      check("clamp_low_ch0", meas[0], 40);
      measure(50, 0, 90);
      measure(-1, 0, 0);
      check("clamp_high_ch0", meas[0], 120);
      measure(50, 2, 65535);
      measure(-1, 0, 0);
      check("clamp_max_ch2", meas[2], 120);

      // write on the load clock, then an invalid channel
      measure(0, 2, 30);
      check("coincide_old_ch2", meas[2], 120);
      measure(-1, 0, 0);
      check("coincide_new_ch2", meas[2], 60);
      measure(50, NUM_CH, 25);
      measure(-1, 0, 0);
      check("invalid_ch2", meas[2], 60);
      check("invalid_ch4", meas[4], 80);

      // watchdog on ch3
      check("wd_pre_fs3", int'(failsafe[3]), 1);
      measure(50, 3, 45);
      check("wd_clear_fs3", int'(failsafe[3]), 0);
      measure(-1, 0, 0);
      check("wd_f1_ch3", meas[3], 90);
      measure(-1, 0, 0);
      check("wd_f2_ch3", meas[3], 90);
      check("wd_f2_fs3", int'(failsafe[3]), 0);
      measure(-1, 0, 0);
      check("wd_f3_ch3", meas[3], 90);
      check("wd_f3_fs3", int'(failsafe[3]), 1);
      measure(-1, 0, 0);
      check("wd_revert_ch3", meas[3], PW_DEF * DIV);
      measure(50, 3, 45);
      check("wd_rewrite_fs3", int'(failsafe[3]), 0);

      // enable drop / raise mid-frame
      repeat (20) @(negedge clk);
      check("en_pre_out0", int'(out[0]), 1);
      ch_en[0] = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (out[0] && k < DIV + 1);
      check("en_drop_out0", int'(out[0]), 0);
      repeat (5) @(negedge clk);
      ch_en[0] = 1'b1;
      hi = 0; k = 0;
      do begin
         @(negedge clk);
         k++;
         hi += int'(out[0]);
      end while (!frame_start && k < 2 * P);
      check("en_no_partial", hi, 0);
      check("en_frame_start_seen", int'(frame_start), 1);
      measure(-1, 0, 0);
      check("en_resume_ch0", meas[0], 80);

      // reset mid-pulse
      repeat (10) @(negedge clk);
      check("rst_pre_out0", int'(out[0]), 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_out", int'(out), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_fs(2 * P, k);
      check("rst_restart", k, P - 1);
      measure(-1, 0, 0);
      check("rst_after_ch1", meas[1], 80);
      check("rst_after_ch2", meas[2], 80);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
